// File: rtl/paddle_calib_pkg.sv
// paddle_calib_pkg: shared types, widths and helpers for the paddle
// calibration sequencer.
//   state_e     : sequencer states (IDLE, ARM, ACCUM, DIVIDE, LOAD)
//   ACC_W       : accumulator width for the default 16x16 box
//   sat_signed  : clamp a signed value into a two's-complement width
package paddle_calib_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    ACCUM  = 3'd2,
    DIVIDE = 3'd3,
    LOAD   = 3'd4
  } state_e;

  localparam int PIX_W            = 9;
  localparam int COORD_W          = 13;
  localparam int BOX_LOG2_DEFAULT = 4;
  localparam int ACC_W            = PIX_W + 2 * BOX_LOG2_DEFAULT;

  // Clamp value to [-2^(width-1), 2^(width-1)-1]; width must be below 32.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi)      sat_signed = hi;
    else if (value < lo) sat_signed = lo;
    else                 sat_signed = value;
  endfunction

endpackage

// File: rtl/paddle_calib_if.sv
// paddle_calib_if: pixel stream from the YUV converter into the calibration
// sequencer.
//   pixel_valid : current pixel is active video
//   row, col    : pixel coordinates (frame start is row 0, col 0)
//   pixel_U/V   : signed 9-bit chroma
// The stream has no back-pressure: the source presents one pixel per clock
// and the sink samples it on every rising edge where pixel_valid is high.
interface paddle_calib_if;
  logic                                       pixel_valid;
  logic        [paddle_calib_pkg::COORD_W-1:0] row;
  logic        [paddle_calib_pkg::COORD_W-1:0] col;
  logic signed [paddle_calib_pkg::PIX_W-1:0]   pixel_U;
  logic signed [paddle_calib_pkg::PIX_W-1:0]   pixel_V;

  modport master (output pixel_valid, row, col, pixel_U, pixel_V);
  modport slave  (input  pixel_valid, row, col, pixel_U, pixel_V);
endinterface

// File: rtl/calib_box_accum.sv
// calib_box_accum: box-hit compare, pixel counter and U/V accumulators for the
// calibration box; optional U/V min/max trackers.
// Optional feature: PADDLE_CALIB_MINMAX_EN builds the extrema trackers and
// their output ports.
//   enable     : pixels may be accepted this cycle
//   clear      : restart the box (new frame); the current pixel is still
//                accepted if it hits the box
//   px         : pixel stream (slave)
//   hit        : current pixel is accepted
//   count_full : all 2^(2*BOX_LOG2) box pixels have been accepted
//   u_sum/v_sum: signed running sums
//   u_min..v_max (feature only): extrema of accepted pixels
module calib_box_accum
  import paddle_calib_pkg::*;
#(
  parameter int BOX_LOG2 = BOX_LOG2_DEFAULT,
  parameter int BOX_COL0 = 312,
  parameter int BOX_ROW0 = 232,
  parameter int SUM_W    = ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clear,
  paddle_calib_if.slave           px,
  output logic                    hit,
  output logic                    count_full,
  output logic signed [SUM_W-1:0] u_sum,
  output logic signed [SUM_W-1:0] v_sum
`ifdef PADDLE_CALIB_MINMAX_EN
  ,
  output logic signed [PIX_W-1:0] u_min,
  output logic signed [PIX_W-1:0] u_max,
  output logic signed [PIX_W-1:0] v_min,
  output logic signed [PIX_W-1:0] v_max
`endif
);

  localparam int CNT_W = 2 * BOX_LOG2 + 1;
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(1) << (2 * BOX_LOG2);
  localparam logic [COORD_W-1:0] ROW_LO   = COORD_W'(BOX_ROW0);
  localparam logic [COORD_W-1:0] ROW_HI   = COORD_W'(BOX_ROW0 + (1 << BOX_LOG2));
  localparam logic [COORD_W-1:0] COL_LO   = COORD_W'(BOX_COL0);
  localparam logic [COORD_W-1:0] COL_HI   = COORD_W'(BOX_COL0 + (1 << BOX_LOG2));

  logic [CNT_W-1:0]        count;
  logic                    in_box;
  logic signed [SUM_W-1:0] u_ext;
  logic signed [SUM_W-1:0] v_ext;

  assign in_box = (px.row >= ROW_LO) && (px.row < ROW_HI) &&
                  (px.col >= COL_LO) && (px.col < COL_HI);
  assign hit        = enable && px.pixel_valid && in_box;
  assign count_full = (count == CNT_FULL);
  assign u_ext      = SUM_W'(px.pixel_U);
  assign v_ext      = SUM_W'(px.pixel_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      u_sum <= '0;
      v_sum <= '0;
    end else if (clear) begin
      count <= hit ? CNT_W'(1) : '0;
      u_sum <= hit ? u_ext : '0;
      v_sum <= hit ? v_ext : '0;
    end else if (hit) begin
      count <= count + CNT_W'(1);
      u_sum <= u_sum + u_ext;
      v_sum <= v_sum + v_ext;
    end
  end

`ifdef PADDLE_CALIB_MINMAX_EN
  // Empty trackers start at the opposite extreme so the first hit wins.
  localparam logic signed [PIX_W-1:0] PIX_MAX = {1'b0, {(PIX_W-1){1'b1}}};
  localparam logic signed [PIX_W-1:0] PIX_MIN = {1'b1, {(PIX_W-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_min <= PIX_MAX;
      u_max <= PIX_MIN;
      v_min <= PIX_MAX;
      v_max <= PIX_MIN;
    end else if (clear) begin
      u_min <= hit ? px.pixel_U : PIX_MAX;
      u_max <= hit ? px.pixel_U : PIX_MIN;
      v_min <= hit ? px.pixel_V : PIX_MAX;
      v_max <= hit ? px.pixel_V : PIX_MIN;
    end else if (hit) begin
      if (px.pixel_U < u_min) u_min <= px.pixel_U;
      if (px.pixel_U > u_max) u_max <= px.pixel_U;
      if (px.pixel_V < v_min) v_min <= px.pixel_V;
      if (px.pixel_V > v_max) v_max <= px.pixel_V;
    end
  end
`endif

endmodule

// File: rtl/paddle_calib_controller.sv
// paddle_calib_controller: on a start request, averages U/V over a fixed pixel
// box of one frame and loads the result into colour slot 1 or 2.
// Optional feature: PADDLE_CALIB_MINMAX_EN also derives per-slot thresholds
// from the U/V spread; otherwise thresholds are fixed at DEFAULT_THRESH.
// Ports:
//   clk, rst_n       : pixel clock, async active-low reset
//   start, color_sel : calibration request and target slot (0 -> 1, 1 -> 2)
//   px               : pixel stream (slave modport)
//   u/vTarget1/2     : registered colour targets
//   u/vThresh1/2     : colour thresholds
//   busy, done       : sequencer active / one-cycle load pulse
//   state_dbg        : current sequencer state
//   box_hit          : a pixel was accepted this cycle
// Handshake: start is a one-cycle request honoured only while busy is low;
// busy rises on the following edge and stays high until the edge after the
// one-cycle done pulse that marks the new targets being visible.
module paddle_calib_controller
  import paddle_calib_pkg::*;
#(
  parameter int THRESH_WIDTH   = 8,
  parameter int BOX_LOG2       = BOX_LOG2_DEFAULT,
  parameter int BOX_COL0       = 312,
  parameter int BOX_ROW0       = 232,
  parameter int DEFAULT_THRESH = 20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           color_sel,
  paddle_calib_if.slave                  px,
  output logic signed [THRESH_WIDTH-1:0] uTarget1,
  output logic signed [THRESH_WIDTH-1:0] vTarget1,
  output logic signed [THRESH_WIDTH-1:0] uTarget2,
  output logic signed [THRESH_WIDTH-1:0] vTarget2,
  output logic signed [THRESH_WIDTH-1:0] uThresh1,
  output logic signed [THRESH_WIDTH-1:0] vThresh1,
  output logic signed [THRESH_WIDTH-1:0] uThresh2,
  output logic signed [THRESH_WIDTH-1:0] vThresh2,
  output logic                           busy,
  output logic                           done,
  output logic [2:0]                     state_dbg,
  output logic                           box_hit
);

  localparam int SUM_W = PIX_W + 2 * BOX_LOG2;
  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_ARM    = 3'(ARM);
  localparam logic [2:0] S_ACCUM  = 3'(ACCUM);
  localparam logic [2:0] S_DIVIDE = 3'(DIVIDE);
  localparam logic [2:0] S_LOAD   = 3'(LOAD);
  localparam logic signed [THRESH_WIDTH-1:0] THR_RST = THRESH_WIDTH'(DEFAULT_THRESH);

  logic [2:0]              state;
  logic [2:0]              state_nxt;
  logic                    sel_q;
  logic                    frame_start;
  logic                    accum_open;
  logic                    acc_clr;
  logic                    acc_en;
  logic                    count_full;
  logic signed [SUM_W-1:0] u_sum;
  logic signed [SUM_W-1:0] v_sum;
  logic signed [31:0]      u_avg;
  logic signed [31:0]      v_avg;

  assign frame_start = px.pixel_valid && (px.row == '0) && (px.col == '0);
  // Once the box is complete, later pixels (and frame starts) must not touch
  // the sums while the FSM moves on to DIVIDE.
  assign accum_open  = (state == S_ACCUM) && !count_full;
  assign acc_clr     = frame_start && ((state == S_ARM) || accum_open);
  assign acc_en      = acc_clr || accum_open;
  assign state_dbg   = state;

`ifdef PADDLE_CALIB_MINMAX_EN
  logic signed [PIX_W-1:0] u_min, u_max, v_min, v_max;
`endif

  calib_box_accum #(
    .BOX_LOG2 (BOX_LOG2),
    .BOX_COL0 (BOX_COL0),
    .BOX_ROW0 (BOX_ROW0),
    .SUM_W    (SUM_W)
  ) u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (acc_en),
    .clear      (acc_clr),
    .px         (px),
    .hit        (box_hit),
    .count_full (count_full),
    .u_sum      (u_sum),
    .v_sum      (v_sum)
`ifdef PADDLE_CALIB_MINMAX_EN
    ,
    .u_min      (u_min),
    .u_max      (u_max),
    .v_min      (v_min),
    .v_max      (v_max)
`endif
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start)       state_nxt = S_ARM;
      S_ARM:    if (frame_start) state_nxt = S_ACCUM;
      S_ACCUM:  if (count_full)  state_nxt = S_DIVIDE;
      S_DIVIDE:                  state_nxt = S_LOAD;
      S_LOAD:                    state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sel_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
      done  <= (state == S_DIVIDE);
      if (state == S_IDLE && start) sel_q <= color_sel;
    end
  end

  // Division by the box size is an arithmetic shift (floor toward -inf).
  always_comb begin
    u_avg = sat_signed(32'(u_sum) >>> (2 * BOX_LOG2), THRESH_WIDTH);
    v_avg = sat_signed(32'(v_sum) >>> (2 * BOX_LOG2), THRESH_WIDTH);
  end

  // Outputs are written on the DIVIDE->LOAD edge so they become visible in
  // the LOAD cycle together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uTarget1 <= '0;
      vTarget1 <= '0;
      uTarget2 <= '0;
      vTarget2 <= '0;
    end else if (state == S_DIVIDE) begin
      if (!sel_q) begin
        uTarget1 <= THRESH_WIDTH'(u_avg);
        vTarget1 <= THRESH_WIDTH'(v_avg);
      end else begin
        uTarget2 <= THRESH_WIDTH'(u_avg);
        vTarget2 <= THRESH_WIDTH'(v_avg);
      end
    end
  end

`ifdef PADDLE_CALIB_MINMAX_EN
  logic signed [31:0] u_spread;
  logic signed [31:0] v_spread;

  // max >= min once the box is full, so the spread is non-negative and only
  // the positive saturation limit can bite.
  always_comb begin
    u_spread = sat_signed(((32'(u_max) - 32'(u_min)) >>> 1) + 32'sd4, THRESH_WIDTH);
    v_spread = sat_signed(((32'(v_max) - 32'(v_min)) >>> 1) + 32'sd4, THRESH_WIDTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uThresh1 <= THR_RST;
      vThresh1 <= THR_RST;
      uThresh2 <= THR_RST;
      vThresh2 <= THR_RST;
    end else if (state == S_DIVIDE) begin
      if (!sel_q) begin
        uThresh1 <= THRESH_WIDTH'(u_spread);
        vThresh1 <= THRESH_WIDTH'(v_spread);
      end else begin
        uThresh2 <= THRESH_WIDTH'(u_spread);
        vThresh2 <= THRESH_WIDTH'(v_spread);
      end
    end
  end
`else
  assign uThresh1 = THR_RST;
  assign vThresh1 = THR_RST;
  assign uThresh2 = THR_RST;
  assign vThresh2 = THR_RST;
`endif

endmodule
